ysyx_25040109_trap_seq: RTL and testbench

Trap sequencer: the initiator side of the register file's single CSR write port. On an exception request it writes mepc, mcause and mstatus one per cycle, then issues a PC redirect to mtvec. On mret it restores mstatus and redirects to mepc. It sits between decode/execute (request source) and the register file (CSR sink), and stalls the core while busy.

---
 rtl/ysyx_25040109_trap_seq_pkg.sv | 31 +++
 rtl/ysyx_25040109_trap_seq_if.sv | 36 +++
 rtl/ysyx_25040109_trap_seq.sv | 119 +++++++++++
 tb/tb_ysyx_25040109_trap_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_trap_seq_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, mstatus field
// positions, FSM state encoding and the request kind captured on accept.
package ysyx_25040109_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  // The core only implements machine mode, so MPP is always forced to M.
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_REDIRECT  = 3'd4
  } trap_state_e;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/ysyx_25040109_trap_seq_if.sv
// Bundle between the trap sequencer, its request source (decode/execute)
// and the CSR register file write/read port. The master modport is the
// sequencer itself; the slave modport is the surrounding core.
interface ysyx_25040109_trap_seq_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  exc_valid;
  logic [DATA_WIDTH-1:0] exc_cause;
  logic [DATA_WIDTH-1:0] exc_pc;
  logic                  mret_valid;
  logic [DATA_WIDTH-1:0] mtvec_in;
  logic [DATA_WIDTH-1:0] mepc_in;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic                  csr_we;
  logic [11:0]           csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  busy;

  modport master (
    input  exc_valid, exc_cause, exc_pc, mret_valid,
    input  mtvec_in, mepc_in, csr_rdata,
    output csr_we, csr_addr, csr_wdata,
    output redirect_valid, redirect_pc, busy
  );

  modport slave (
    output exc_valid, exc_cause, exc_pc, mret_valid,
    output mtvec_in, mepc_in, csr_rdata,
    input  csr_we, csr_addr, csr_wdata,
    input  redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/ysyx_25040109_trap_seq.sv
// Trap sequencer: drives the register file's single CSR write port to take
// an exception (mepc, mcause, mstatus, then redirect to mtvec) or to return
// from one (mstatus, then redirect to mepc). Stalls the core while busy.
// Optional feature macro: TRAP_MSTATUS_UPDATE_EN. When undefined the mstatus
// write step is skipped and mstatus is never touched by this block.
module ysyx_25040109_trap_seq
  import ysyx_25040109_trap_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_25040109_trap_seq_if.master        bus
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  trap_state_e           state_q, state_d;
  trap_kind_e            kind_q, kind_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] mstatus_upd;

  // State and request captures; a synchronous reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_EXC;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state: accept only in IDLE (exception beats mret), then step through.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.exc_valid) begin
          kind_d  = KIND_EXC;
          pc_d    = bus.exc_pc;
          cause_d = bus.exc_cause;
          state_d = ST_W_MEPC;
        end else if (bus.mret_valid) begin
          kind_d  = KIND_MRET;
`ifdef TRAP_MSTATUS_UPDATE_EN
          state_d = ST_W_MSTATUS;
`else
          state_d = ST_REDIRECT;
`endif
        end
      end
      ST_W_MEPC:    state_d = ST_W_MCAUSE;
      ST_W_MCAUSE: begin
`ifdef TRAP_MSTATUS_UPDATE_EN
        state_d = ST_W_MSTATUS;
`else
        state_d = ST_REDIRECT;
`endif
      end
      ST_W_MSTATUS: state_d = ST_REDIRECT;
      ST_REDIRECT:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; mstatus is patched from live read data.
  always_comb begin
    bus.csr_we         = 1'b0;
    bus.csr_addr       = '0;
    bus.csr_wdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.busy           = (state_q != ST_IDLE);

    mstatus_upd = bus.csr_rdata;
    mstatus_upd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    if (kind_q == KIND_EXC) begin
      mstatus_upd[MSTATUS_MPIE] = bus.csr_rdata[MSTATUS_MIE];
      mstatus_upd[MSTATUS_MIE]  = 1'b0;
    end else begin
      mstatus_upd[MSTATUS_MIE]  = bus.csr_rdata[MSTATUS_MPIE];
      mstatus_upd[MSTATUS_MPIE] = 1'b1;
    end

    case (state_q)
      ST_W_MEPC: begin
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MEPC;
        bus.csr_wdata = pc_q & ALIGN_MASK;
      end
      ST_W_MCAUSE: begin
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MCAUSE;
        bus.csr_wdata = cause_q;
      end
      ST_W_MSTATUS: begin
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MSTATUS;
        bus.csr_wdata = mstatus_upd;
      end
      ST_REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = (kind_q == KIND_EXC) ? (bus.mtvec_in & ALIGN_MASK)
                                                  : bus.mepc_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040109_trap_seq.sv
// Scoreboard bench for the trap sequencer. A small CSR file model answers
// reads and absorbs writes; a reference model predicts every CSR write and
// redirect (with its cycle) into a queue that a negedge monitor drains.
// Honours TRAP_MSTATUS_UPDATE_EN the same way the design does.
module tb_ysyx_25040109_trap_seq;

  localparam int DW = 32;

  typedef struct packed {
    int          cyc;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ysyx_25040109_trap_seq_if #(.DATA_WIDTH(DW)) bus ();

  ysyx_25040109_trap_seq #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rf_mstatus = 32'h0;
  logic [31:0] rf_mtvec   = 32'h0;
  logic [31:0] rf_mepc    = 32'h0;
  logic [31:0] rf_mcause  = 32'h0;
  logic        sw_we      = 1'b0;
  logic [11:0] sw_addr    = 12'h0;
  logic [31:0] sw_data    = 32'h0;

  // CSR file: sequencer writes plus occasional software writes while idle
  always @(posedge clk) begin
    if (bus.csr_we) begin
      case (bus.csr_addr)
        12'h300: rf_mstatus <= bus.csr_wdata;
        12'h305: rf_mtvec   <= bus.csr_wdata;
        12'h341: rf_mepc    <= bus.csr_wdata;
        12'h342: rf_mcause  <= bus.csr_wdata;
        default: ;
      endcase
    end else if (sw_we) begin
      case (sw_addr)
        12'h300: rf_mstatus <= sw_data;
        12'h305: rf_mtvec   <= sw_data;
        12'h341: rf_mepc    <= sw_data;
        12'h342: rf_mcause  <= sw_data;
        default: ;
      endcase
    end
  end

  // Combinational CSR read port
  always_comb begin
    bus.csr_rdata = 32'h0;
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = rf_mstatus;
      12'h305: bus.csr_rdata = rf_mtvec;
      12'h341: bus.csr_rdata = rf_mepc;
      12'h342: bus.csr_rdata = rf_mcause;
      default: ;
    endcase
  end

  assign bus.mtvec_in = rf_mtvec;
  assign bus.mepc_in  = rf_mepc;

  ev_t         exp_q[$];
  logic [31:0] sh_mstatus = 32'h0;
  logic [31:0] sh_mtvec   = 32'h0;
  logic [31:0] sh_mepc    = 32'h0;
  logic [31:0] sh_mstatus_saved = 32'h0;
  int          free_cyc  = 0;
  int          busy_from = 0;
  int          last_acc  = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  ev_t         mon_exp;
  ev_t         mon_act;
  logic        exp_busy;

  // Trap entry: interrupts off, old enable kept in MPIE, previous privilege M.
  function automatic logic [31:0] ref_trap_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | ((s & 32'h8) << 4) | 32'h0000_1800;
  endfunction

  // Trap return: enable restored from MPIE, MPIE set, privilege stays M.
  function automatic logic [31:0] ref_ret_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | ((s >> 4) & 32'h8) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  function automatic ev_t mk_write(input int c, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e = '0;
    e.cyc = c; e.we = 1'b1; e.addr = a; e.wdata = d;
    return e;
  endfunction

  function automatic ev_t mk_redirect(input int c, input logic [31:0] pc);
    ev_t e;
    e = '0;
    e.cyc = c; e.rv = 1'b1; e.rpc = pc;
    return e;
  endfunction

  task automatic model_exception(input int acc, input logic [31:0] cause, input logic [31:0] pc);
    int k;
    k = acc + 1;
    sh_mstatus_saved = sh_mstatus;
    exp_q.push_back(mk_write(k, 12'h341, pc & ~32'h3)); k++;
    sh_mepc = pc & ~32'h3;
    exp_q.push_back(mk_write(k, 12'h342, cause)); k++;
`ifdef TRAP_MSTATUS_UPDATE_EN
    sh_mstatus = ref_trap_status(sh_mstatus);
    exp_q.push_back(mk_write(k, 12'h300, sh_mstatus)); k++;
`endif
    exp_q.push_back(mk_redirect(k, sh_mtvec & ~32'h3));
    busy_from = acc + 1;
    free_cyc  = k + 1;
  endtask

  task automatic model_mret(input int acc);
    int k;
    k = acc + 1;
    sh_mstatus_saved = sh_mstatus;
`ifdef TRAP_MSTATUS_UPDATE_EN
    sh_mstatus = ref_ret_status(sh_mstatus);
    exp_q.push_back(mk_write(k, 12'h300, sh_mstatus)); k++;
`endif
    exp_q.push_back(mk_redirect(k, sh_mepc));
    busy_from = acc + 1;
    free_cyc  = k + 1;
  endtask

  // Reset from cycle at_cyc on: later events never happen, mstatus keeps its old value.
  task automatic model_abort(input int at_cyc);
    ev_t keep[$];
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc < at_cyc) keep.push_back(exp_q[i]);
      else if (exp_q[i].we && exp_q[i].addr == 12'h300) sh_mstatus = sh_mstatus_saved;
    end
    exp_q    = keep;
    free_cyc = at_cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sw_we = 1'b1; sw_addr = a; sw_data = d;
    case (a)
      12'h300: sh_mstatus = d;
      12'h305: sh_mtvec   = d;
      12'h341: sh_mepc    = d;
      default: ;
    endcase
    @(posedge clk); #1;
    sw_we = 1'b0;
  endtask

  task automatic applyStimulus(input bit e, input bit m, input logic [31:0] cause,
                               input logic [31:0] pc);
    @(posedge clk); #1;
    bus.exc_valid  = e;
    bus.mret_valid = m;
    bus.exc_cause  = cause;
    bus.exc_pc     = pc;
    if (cyc >= free_cyc) begin
      if (e) begin
        last_acc = cyc;
        model_exception(cyc, cause, pc);
      end else if (m) begin
        last_acc = cyc;
        model_mret(cyc);
      end
    end
    @(posedge clk); #1;
    bus.exc_valid  = 1'b0;
    bus.mret_valid = 1'b0;
    bus.exc_cause  = $urandom;
    bus.exc_pc     = $urandom;
  endtask

  task automatic checkOutput(input string name, input ev_t e, input ev_t a);
    checks++;
    if (a.we !== e.we || a.addr !== e.addr || a.wdata !== e.wdata ||
        a.rv !== e.rv || a.rpc !== e.rpc) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got we=%b addr=%h wdata=%h rv=%b rpc=%h expected we=%b addr=%h wdata=%h rv=%b rpc=%h",
               name, e.cyc, a.we, a.addr, a.wdata, a.rv, a.rpc,
               e.we, e.addr, e.wdata, e.rv, e.rpc);
    end
  endtask

  // Monitor: every cycle compare the bus against the predicted event or idle zeros
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_exp = '0;
        mon_exp.cyc = cyc;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) mon_exp = exp_q.pop_front();
        mon_act = '0;
        mon_act.cyc   = cyc;
        mon_act.we    = bus.csr_we;
        mon_act.addr  = bus.csr_addr;
        mon_act.wdata = bus.csr_wdata;
        mon_act.rv    = bus.redirect_valid;
        mon_act.rpc   = bus.redirect_pc;
        checkOutput("csr_redirect", mon_exp, mon_act);
        exp_busy = (cyc >= busy_from) && (cyc < free_cyc);
        checks++;
        if (bus.busy !== exp_busy) begin
          errors++;
          $display("[TB] FAIL busy cyc=%0d got %b expected %b", cyc, bus.busy, exp_busy);
        end
      end
    end
  end

  // Directed scenarios, then randomized traffic, then drain and summary
  initial begin
    int unsigned r;
    bus.exc_valid  = 1'b0;
    bus.mret_valid = 1'b0;
    bus.exc_cause  = 32'h0;
    bus.exc_pc     = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    $display("[TB] reset released, idling");
    wait_cycles(10);

    $display("[TB] exception path");
    sw_write(12'h300, 32'h0000_1808);
    sw_write(12'h305, 32'h8000_0200);
    applyStimulus(1'b1, 1'b0, 32'd11, 32'h8000_0104);
    wait_cycles(6);

    $display("[TB] mret path");
    sw_write(12'h300, 32'h0000_1880);
    sw_write(12'h341, 32'h8000_0108);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    wait_cycles(4);

    $display("[TB] simultaneous exception and mret");
    applyStimulus(1'b1, 1'b1, 32'd2, 32'h8000_0303);
    wait_cycles(6);

    $display("[TB] mret while busy");
    applyStimulus(1'b1, 1'b0, 32'd3, 32'h8000_0400);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    wait_cycles(6);

    $display("[TB] reset during mcause write");
    applyStimulus(1'b1, 1'b0, 32'd7, 32'h8000_0502);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_abort(last_acc + 3);
    wait_cycles(3);

    $display("[TB] random traffic");
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: if (cyc >= free_cyc) sw_write(12'h300, $urandom); else wait_cycles(1);
        2:    if (cyc >= free_cyc) sw_write(12'h305, $urandom); else wait_cycles(1);
        3:    if (cyc >= free_cyc) sw_write(12'h341, $urandom); else wait_cycles(1);
        4, 5: applyStimulus(1'b1, 1'b0, $urandom, $urandom);
        6, 7: applyStimulus(1'b0, 1'b1, $urandom, $urandom);
        8:    applyStimulus(1'b1, 1'b1, $urandom, $urandom);
        default: wait_cycles($urandom_range(1, 3));
      endcase
    end

    for (int i = 0; i < 40 && (exp_q.size() != 0 || cyc < free_cyc); i++) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending events expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
